ibex_pext_md_ctrl: RTL and testbench
====================================

# ibex_pext_md_ctrl

Sequencer for the P-extension execute datapath (`ibex_alu_pext` with its embedded multiply/divide unit). It accepts one instruction at a time from the ID stage and drives `mult_en`/`div_en`/`multdiv_ready_id`. It owns the two 34-bit intermediate-value registers (`imd_val_q`) and waits for the datapath `valid`. The result and overflow flag are registered toward writeback, and the sticky `vxsat` saturation flag is maintained here.

## Interface
- `MaxCycles`, default 40: watchdog limit on cycles spent in RUN.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; **synchronous and active-low**.
- `req_valid_i`  in  1  ID presents an instruction.
- `req_ready_o`  out  1  controller accepts the instruction this cycle.
- `req_mult_i`  in  1  instruction is a multi-cycle multiply.
- `req_div_i`  in  1  instruction is a multi-cycle divide; mutually exclusive with `req_mult_i`.
- `kill_i`  in  1  flush; abandon the current instruction.
- `mult_en_o`  out  1  drives datapath `mult_en_i`/`mult_sel_i`.
- `div_en_o`  out  1  drives datapath `div_en_i`/`div_sel_i`.
- `multdiv_ready_id_o`  out  1  drives datapath `multdiv_ready_id_i`.
- `alu_valid_i`  in  1  datapath `valid_o`.
- `alu_result_i`  in  32  datapath `result_o`.
- `alu_set_ov_i`  in  1  datapath `set_ov_o`.
- `imd_val_we_i`  in  2  datapath write enables.
- `imd_val_d_i`  in  2x34  datapath next intermediate values.
- `imd_val_q_o`  out  2x34  intermediate registers fed back to the datapath.
- `wb_valid_o`  out  1  registered result available.
- `wb_ready_i`  in  1  writeback consumes the result.
- `wb_result_o`  out  32  registered result.
- `vxsat_o`  out  1  sticky saturation flag.
- `vxsat_we_i`  in  1  CSR write to `vxsat`.
- `vxsat_wdata_i`  in  1  CSR write data.
- `timeout_o`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, RUN, WB.
- **IDLE**
  - `req_ready_o` = 1.
  - `req_valid_i` with neither `req_mult_i` nor `req_div_i` (single-cycle op): capture `alu_result_i`; OR `alu_set_ov_i` into vxsat; go to WB.
  - `req_valid_i` with `req_mult_i` or `req_div_i`: latch the type, clear the cycle counter, go to RUN.
- **RUN**
  - `req_ready_o` = 0.
  - `mult_en_o`/`div_en_o` follow the latched type.
  - `multdiv_ready_id_o` = 1 in the first RUN cycle only.
  - Each cycle, imd register r loads `imd_val_d_i[r]` when `imd_val_we_i[r]`.
  - On `alu_valid_i`: capture the result, OR `set_ov` into vxsat, deassert the enables, go to WB.
  - Counter reaching `MaxCycles`-1 without valid: pulse `timeout_o`, capture 32'h0, go to WB.
- **WB**
  - `wb_valid_o` = 1; result held stable until `wb_ready_i`.
  - On `wb_ready_i`: go to IDLE. No back-to-back acceptance; `req_ready_o` is 0 in WB.
- **kill_i** (any state): go to IDLE next cycle; enables, `wb_valid_o` and the counter clear. The imd registers and vxsat are **not** cleared. A vxsat update arriving in the same cycle as `kill_i` is discarded.
- **vxsat**
  - CSR write has priority over a same-cycle saturation set.
  - Otherwise the flag is sticky: set-only from the datapath.
- **Reset**
  - Go to IDLE.
  - All outputs 0 except `req_ready_o` = 1.
  - `imd_val_q_o`, vxsat, result and counter are all 0.

## Timing
- Single-cycle op: accepted in cycle N; `wb_valid_o` in N+1.
- Multi-cycle op: enables active from N+1. `alu_valid_i` arrives in cycle M; `wb_valid_o` in M+1.
- `imd_val_q_o` updates on the edge after a `we` cycle.
- Enables are registered state decodes; no combinational path from `alu_valid_i` to them.
- Counter width is clog2(`MaxCycles`) and does not wrap; it stops at expiry.
- `vxsat_o` reflects an update one cycle after the event.

## Structure
- Shared package `ibex_pkg_pext` holds:
  - the state enum `pext_md_state_e` (`MD_CTRL_IDLE`, `MD_CTRL_RUN`, `MD_CTRL_WB`);
  - the imd width constant (34).
- Single module; no sub-module.
- The bench wraps it around `ibex_alu_pext`.

## Test plan
- **Single-cycle op.** `ZPN_KSLLW`, a=32'hff7fffff, b=8, saturates.
  - `wb_valid_o` one cycle after accept.
  - Result 32'h80000000.
  - `vxsat_o` = 1 on the following cycle.
- **Multiply.** `MD_OP_MULL` with `req_mult_i`, a=32'h00000003, b=32'h00000005.
  - Enables held until valid.
  - Result 32'h0000000f.
  - `imd_val_q_o` follows `imd_val_d_i` on every we cycle.
- **Divide by zero with stalled writeback.** `req_div_i`, b=0.
  - Result 32'hffffffff.
  - `wb_ready_i` held low 3 cycles: result stays stable, `req_ready_o` stays 0.
- **Kill mid-RUN.** `kill_i` in the 2nd RUN cycle.
  - IDLE next cycle, enables 0, no `wb_valid_o`.
  - vxsat unchanged.
- **Watchdog.** `MaxCycles`=4, `alu_valid_i` tied 0.
  - `timeout_o` pulses on the 4th RUN cycle.
  - `wb_result_o` = 0.
- **vxsat write priority.**
  - `vxsat_we_i`=1 with `vxsat_wdata_i`=0 in the same cycle as a saturating set → `vxsat_o` = 0.
  - Synchronous reset mid-RUN → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the P-extension execute sequencer.
package ibex_pkg_pext;

    localparam int unsigned IMD_W = 34;

    typedef enum logic [1:0] {
        MD_CTRL_IDLE = 2'd0,
        MD_CTRL_RUN  = 2'd1,
        MD_CTRL_WB   = 2'd2
    } pext_md_state_e;

endpackage

// File: rtl/ibex_pext_md_ctrl.sv
// Sequencer for the P-extension multiply/divide datapath: accepts one instruction,
// holds the intermediate registers, registers the result and keeps the sticky vxsat flag.
module ibex_pext_md_ctrl
    import ibex_pkg_pext::*;
#(
    parameter int unsigned MaxCycles = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_mult_i,
    input  logic                  req_div_i,
    input  logic                  kill_i,

    output logic                  mult_en_o,
    output logic                  div_en_o,
    output logic                  multdiv_ready_id_o,
    input  logic                  alu_valid_i,
    input  logic [31:0]           alu_result_i,
    input  logic                  alu_set_ov_i,
    input  logic [1:0]            imd_val_we_i,
    input  logic [1:0][IMD_W-1:0] imd_val_d_i,
    output logic [1:0][IMD_W-1:0] imd_val_q_o,

    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [31:0]           wb_result_o,

    output logic                  vxsat_o,
    input  logic                  vxsat_we_i,
    input  logic                  vxsat_wdata_i,
    output logic                  timeout_o
);

    localparam int unsigned    CntW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MaxCycles - 1);

    pext_md_state_e        state_q, state_d;
    logic                  is_div_q, is_div_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [31:0]           result_q, result_d;
    logic                  vxsat_q, vxsat_d;
    logic [1:0][IMD_W-1:0] imd_q, imd_d;
    logic                  sat_set;
    logic                  timeout_c;

    // Next-state, capture and watchdog decisions.
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        imd_d     = imd_q;
        sat_set   = 1'b0;
        timeout_c = 1'b0;

        case (state_q)
            MD_CTRL_IDLE: begin
                if (req_valid_i) begin
                    if (req_mult_i || req_div_i) begin
                        is_div_d = req_div_i;
                        cnt_d    = '0;
                        state_d  = MD_CTRL_RUN;
                    end else begin
                        result_d = alu_result_i;
                        sat_set  = alu_set_ov_i;
                        state_d  = MD_CTRL_WB;
                    end
                end
            end
            MD_CTRL_RUN: begin
                for (int r = 0; r < 2; r++) begin
                    if (imd_val_we_i[r]) begin
                        imd_d[r] = imd_val_d_i[r];
                    end
                end
                if (alu_valid_i) begin
                    result_d = alu_result_i;
                    sat_set  = alu_set_ov_i;
                    state_d  = MD_CTRL_WB;
                end else if (cnt_q == CntLast) begin
                    timeout_c = 1'b1;
                    result_d  = 32'h0;
                    state_d   = MD_CTRL_WB;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            MD_CTRL_WB: begin
                if (wb_ready_i) begin
                    state_d = MD_CTRL_IDLE;
                end
            end
            default: begin
                state_d = MD_CTRL_IDLE;
            end
        endcase

        // A flush abandons the instruction but leaves imd contents and vxsat alone.
        if (kill_i) begin
            state_d   = MD_CTRL_IDLE;
            cnt_d     = '0;
            result_d  = result_q;
            sat_set   = 1'b0;
            timeout_c = 1'b0;
        end

        vxsat_d = vxsat_we_i ? vxsat_wdata_i : (vxsat_q | sat_set);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= MD_CTRL_IDLE;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= 32'h0;
            vxsat_q  <= 1'b0;
            imd_q    <= '0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            vxsat_q  <= vxsat_d;
            imd_q    <= imd_d;
        end
    end

    // Handshake and enables are pure decodes of registered state.
    assign req_ready_o        = (state_q == MD_CTRL_IDLE);
    assign mult_en_o          = (state_q == MD_CTRL_RUN) && !is_div_q;
    assign div_en_o           = (state_q == MD_CTRL_RUN) &&  is_div_q;
    assign multdiv_ready_id_o = (state_q == MD_CTRL_RUN) && (cnt_q == '0);
    assign wb_valid_o         = (state_q == MD_CTRL_WB);
    assign wb_result_o        = result_q;
    assign vxsat_o            = vxsat_q;
    assign imd_val_q_o        = imd_q;
    assign timeout_o          = timeout_c;

endmodule

// File: tb/tb_ibex_pext_md_ctrl.sv
// Randomized self-checking bench for ibex_pext_md_ctrl; the bench plays the datapath
// and predicts each transaction's outcome from latency, result and overflow.
module tb_ibex_pext_md_ctrl;
    import ibex_pkg_pext::*;

    localparam int unsigned MC = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  req_valid_i, req_ready_o, req_mult_i, req_div_i, kill_i;
    logic                  mult_en_o, div_en_o, multdiv_ready_id_o;
    logic                  alu_valid_i, alu_set_ov_i;
    logic [31:0]           alu_result_i;
    logic [1:0]            imd_val_we_i;
    logic [1:0][IMD_W-1:0] imd_val_d_i, imd_val_q_o;
    logic                  wb_valid_o, wb_ready_i;
    logic [31:0]           wb_result_o;
    logic                  vxsat_o, vxsat_we_i, vxsat_wdata_i, timeout_o;

    int                    n_checks = 0;
    int                    n_fail   = 0;
    logic                  vxsat_m;
    logic [1:0][IMD_W-1:0] imd_m;

    ibex_pext_md_ctrl #(.MaxCycles(MC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_mult_i(req_mult_i), .req_div_i(req_div_i), .kill_i(kill_i),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o), .multdiv_ready_id_o(multdiv_ready_id_o),
        .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i), .alu_set_ov_i(alu_set_ov_i),
        .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(imd_val_q_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
        .vxsat_o(vxsat_o), .vxsat_we_i(vxsat_we_i), .vxsat_wdata_i(vxsat_wdata_i),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Saturating signed left shift, computed in 64-bit arithmetic: {ov, result}.
    function automatic logic [32:0] ksllw(input logic [31:0] a, input int sh);
        longint sa = longint'($signed(a));
        longint p  = sa * (longint'(1) << sh);
        if (p > longint'(32'sh7fffffff))  return {1'b1, 32'h7fffffff};
        if (p < -longint'(64'sd2147483648)) return {1'b1, 32'h80000000};
        return {1'b0, p[31:0]};
    endfunction

    function automatic logic [IMD_W-1:0] rnd34();
        return {2'($urandom), $urandom};
    endfunction

    task automatic idle_inputs();
        req_valid_i = 0; req_mult_i = 0; req_div_i = 0; kill_i = 0;
        alu_valid_i = 0; alu_set_ov_i = 0; alu_result_i = $urandom;
        imd_val_we_i = 0; imd_val_d_i = {rnd34(), rnd34()};
        wb_ready_i = 0; vxsat_we_i = 0; vxsat_wdata_i = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_en"}, 64'({mult_en_o, div_en_o, multdiv_ready_id_o}), 64'd0);
        chk({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_res"}, 64'(wb_result_o), 64'd0);
        chk({tag, "_vxsat"}, 64'(vxsat_o), 64'd0);
        chk({tag, "_imd0"}, 64'(imd_val_q_o[0]), 64'd0);
        chk({tag, "_imd1"}, 64'(imd_val_q_o[1]), 64'd0);
        chk({tag, "_tmo"}, 64'(timeout_o), 64'd0);
    endtask

    // Hold writeback for 'stall' cycles, then consume; result must stay put.
    task automatic drain(input string tag, input int stall, input logic [31:0] exp_res);
        for (int i = 0; i < stall; i++) begin
            wb_ready_i = 0;
            #1;
            chk({tag, "_stall_wbv"}, 64'(wb_valid_o), 64'd1);
            chk({tag, "_stall_res"}, 64'(wb_result_o), 64'(exp_res));
            chk({tag, "_stall_rdy"}, 64'(req_ready_o), 64'd0);
            cyc();
        end
        wb_ready_i = 1;
        #1;
        chk({tag, "_wb_res"}, 64'(wb_result_o), 64'(exp_res));
        cyc();
        wb_ready_i = 0;
        #1;
        chk({tag, "_post_wbv"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_post_rdy"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_post_vxsat"}, 64'(vxsat_o), 64'(vxsat_m));
    endtask

    task automatic run_single(input string tag, input logic [31:0] res, input logic ov,
                              input logic csr_we, input logic csr_wd, input int stall);
        req_valid_i = 1; alu_result_i = res; alu_set_ov_i = ov;
        vxsat_we_i = csr_we; vxsat_wdata_i = csr_wd;
        #1;
        chk({tag, "_acc_rdy"}, 64'(req_ready_o), 64'd1);
        vxsat_m = csr_we ? csr_wd : (vxsat_m | ov);
        cyc();
        idle_inputs();
        chk({tag, "_wbv"}, 64'(wb_valid_o), 64'd1);
        chk({tag, "_res"}, 64'(wb_result_o), 64'(res));
        chk({tag, "_vxsat"}, 64'(vxsat_o), 64'(vxsat_m));
        drain(tag, stall, res);
    endtask

    // lat: RUN cycle on which the datapath raises valid (beyond MC means never).
    task automatic run_multi(input string tag, input logic is_div, input int lat,
                             input logic [31:0] res, input logic ov, input int stall);
        logic valid;
        req_valid_i = 1; req_mult_i = !is_div; req_div_i = is_div;
        #1;
        chk({tag, "_acc_rdy"}, 64'(req_ready_o), 64'd1);
        cyc();
        idle_inputs();
        for (int k = 1; k <= int'(MC); k++) begin
            chk({tag, "_imd0"}, 64'(imd_val_q_o[0]), 64'(imd_m[0]));
            chk({tag, "_imd1"}, 64'(imd_val_q_o[1]), 64'(imd_m[1]));
            valid = (k == lat);
            imd_val_we_i = 2'($urandom);
            imd_val_d_i  = {rnd34(), rnd34()};
            alu_valid_i  = valid;
            alu_result_i = valid ? res : $urandom;
            alu_set_ov_i = valid ? ov : 1'($urandom);
            #1;
            chk({tag, "_mul_en"}, 64'(mult_en_o), 64'(!is_div));
            chk({tag, "_div_en"}, 64'(div_en_o), 64'(is_div));
            chk({tag, "_mdr"}, 64'(multdiv_ready_id_o), 64'(k == 1));
            chk({tag, "_run_rdy"}, 64'(req_ready_o), 64'd0);
            chk({tag, "_run_wbv"}, 64'(wb_valid_o), 64'd0);
            chk({tag, "_tmo"}, 64'(timeout_o), 64'(!valid && k == int'(MC)));
            for (int r = 0; r < 2; r++) if (imd_val_we_i[r]) imd_m[r] = imd_val_d_i[r];
            if (valid && ov) vxsat_m = 1'b1;
            cyc();
            idle_inputs();
            if (valid || k == int'(MC)) break;
        end
        chk({tag, "_imd0_end"}, 64'(imd_val_q_o[0]), 64'(imd_m[0]));
        chk({tag, "_imd1_end"}, 64'(imd_val_q_o[1]), 64'(imd_m[1]));
        chk({tag, "_wbv"}, 64'(wb_valid_o), 64'd1);
        chk({tag, "_en_off"}, 64'({mult_en_o, div_en_o}), 64'd0);
        chk({tag, "_wb_tmo"}, 64'(timeout_o), 64'd0);
        chk({tag, "_vxsat"}, 64'(vxsat_o), 64'(vxsat_m));
        drain(tag, stall, (lat <= int'(MC)) ? res : 32'h0);
    endtask

    // Kill in the 2nd RUN cycle, racing a valid with a saturation set.
    task automatic run_kill(input string tag, input logic is_div);
        req_valid_i = 1; req_mult_i = !is_div; req_div_i = is_div;
        cyc();
        idle_inputs();
        cyc();
        kill_i = 1; alu_valid_i = 1; alu_set_ov_i = 1; alu_result_i = $urandom;
        #1;
        chk({tag, "_kill_tmo"}, 64'(timeout_o), 64'd0);
        cyc();
        idle_inputs();
        chk({tag, "_rdy"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_en"}, 64'({mult_en_o, div_en_o, multdiv_ready_id_o}), 64'd0);
        chk({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_vxsat"}, 64'(vxsat_o), 64'(vxsat_m));
        cyc();
        chk({tag, "_wbv2"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_rdy2"}, 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        logic [32:0] ks;
        idle_inputs();
        rst_ni  = 0;
        vxsat_m = 0;
        imd_m   = '0;
        cyc();
        cyc();
        chk_reset_state("rst");
        rst_ni = 1;
        cyc();

        ks = ksllw(32'hff7fffff, 8);
        run_single("ksllw", ks[31:0], ks[32], 1'b0, 1'b0, 0);
        chk("ksllw_val", 64'(ks), 64'h1_8000_0000);

        run_multi("mull", 1'b0, 3, 32'(64'd3 * 64'd5), 1'b0, 1);
        run_multi("div0", 1'b1, 3, 32'hffffffff, 1'b0, 3);

        run_single("vxprio", ks[31:0], 1'b1, 1'b1, 1'b0, 0);
        run_kill("kill", 1'b0);
        run_multi("wdog", 1'b1, 99, 32'h12345678, 1'b1, 1);
        run_multi("last", 1'b0, int'(MC), 32'hcafef00d, 1'b1, 0);

        req_valid_i = 1; req_mult_i = 1;
        cyc();
        idle_inputs();
        cyc();
        imd_val_we_i = 2'b11; imd_val_d_i = {rnd34(), rnd34()};
        rst_ni = 0;
        cyc();
        vxsat_m = 0;
        imd_m   = '0;
        chk_reset_state("rst_run");
        rst_ni = 1;
        cyc();

        for (int it = 0; it < 40; it++) begin
            int sel   = int'($urandom_range(0, 3));
            int lat   = int'($urandom_range(1, 6));
            int stall = int'($urandom_range(0, 2));
            logic ov  = ($urandom_range(0, 3) == 0);
            case (sel)
                0:       run_single("r_single", $urandom, ov, 1'($urandom_range(0, 4) == 0),
                                    1'($urandom), stall);
                1:       run_multi("r_mult", 1'b0, lat, $urandom, ov, stall);
                2:       run_multi("r_div", 1'b1, lat, $urandom, ov, stall);
                default: run_kill("r_kill", 1'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
